// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload from a valid/ready stream, then
// sends header, payload and parity without gaps, holding the bus only while busy is high.
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [5:0] cmd_len,
  output logic       cmd_err,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic [7:0] pay_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_done,
  output logic       tx_active
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [6:0] MAX_L = 7'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  state_t        state;
  logic [1:0]    dest;
  logic [5:0]    len;
  logic [7:0]    parity_acc;
  logic [5:0]    wr_idx;
  logic [5:0]    rd_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    mem [0:MAX_LEN-1];

  logic [5:0] rd_nxt;
  logic       cmd_bad;
  logic       wr_en;

  assign rd_nxt  = rd_idx + 6'd1;
  assign cmd_bad = (cmd_dest == 2'b11) || (cmd_len == 6'd0) || ({1'b0, cmd_len} > MAX_L);
  assign wr_en   = (state == LOAD) && pay_valid;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx[AW-1:0]] <= pay_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dest       <= 2'd0;
      len        <= 6'd0;
      parity_acc <= 8'h00;
      wr_idx     <= 6'd0;
      rd_idx     <= 6'd0;
      gap_cnt    <= '0;
      cmd_ready  <= 1'b1;
      cmd_err    <= 1'b0;
      pay_ready  <= 1'b0;
      pkt_valid  <= 1'b0;
      data_out   <= 8'h00;
      tx_done    <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              cmd_err <= 1'b1;
            end else begin
              dest       <= cmd_dest;
              len        <= cmd_len;
              parity_acc <= {cmd_len, cmd_dest};
              wr_idx     <= 6'd0;
              state      <= LOAD;
              cmd_ready  <= 1'b0;
              pay_ready  <= 1'b1;
              tx_active  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (pay_valid) begin
            parity_acc <= parity_acc ^ pay_data;
            wr_idx     <= wr_idx + 6'd1;
            if (wr_idx == len - 6'd1) begin
              state     <= HEADER;
              pay_ready <= 1'b0;
              pkt_valid <= 1'b1;
              data_out  <= {len, dest};
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            rd_idx   <= 6'd0;
            state    <= PAYLOAD;
            data_out <= mem[0];
          end
        end
        PAYLOAD: begin
          // Next byte is fetched on the transfer edge so data_out stays a plain register.
          if (!busy) begin
            if (rd_idx == len - 6'd1) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
              data_out  <= parity_acc;
            end else begin
              rd_idx   <= rd_nxt;
              data_out <= mem[rd_nxt[AW-1:0]];
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            state    <= GAP;
            data_out <= 8'h00;
            tx_done  <= 1'b1;
            gap_cnt  <= GW'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= IDLE;
            tx_active <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
